spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//  Parametrised SPI (mode 0, MSB first) peripheral register bank with write and read-back.
//  Frame = 1 R/W bit + ADDR_W address bits + DATA_W data bits; replaces fixed 16-bit write-only front end.
//  Sits between the external SPI pins and the config consumers (output enables, PWM enables/duty).
//  Exposes the NUM_REGS registers as one flat bus plus a write strobe.
// PARAMETERS
//  ADDR_W       7    address field width (bits)
//  DATA_W       8    register/data field width (bits)
//  NUM_REGS     5    implemented registers, addresses 0..NUM_REGS-1 (NUM_REGS <= 2**ADDR_W)
//  SYNC_STAGES  2    synchroniser flops on sclk, copi and ncs (>= 2)
//  RESET_VALS   0    NUM_REGS*DATA_W reset image; reg i resets to RESET_VALS[i*DATA_W +: DATA_W]
// PORTS
//  clk        in   1                  system clock, >= 8x sclk
//  rst_n      in   1                  reset, synchronous, active-low
//  ncs        in   1                  chip select, active low (async to clk)
//  sclk       in   1                  SPI clock (async to clk)
//  copi       in   1                  controller-out peripheral-in
//  cipo       out  1                  controller-in peripheral-out data
//  cipo_oe    out  1                  cipo output enable (high only while driving read data)
//  regs_flat  out  NUM_REGS*DATA_W    register contents, reg i at [i*DATA_W +: DATA_W]
//  wr_stb     out  1                  one-clk pulse when a register is written
//  wr_addr    out  ADDR_W             address of the write; valid with wr_stb
//  err_abort  out  1                  one-clk pulse when ncs rises mid-frame
// BEHAVIOUR
//  Reset: regs_flat=RESET_VALS; cipo, cipo_oe, wr_stb, err_abort=0; wr_addr=0; state IDLE; sync chains 0.
//  Sync: all three inputs pass SYNC_STAGES flops; edges detected on last two synced samples of each.
//  sclk rise: sample synced copi; sclk fall: update cipo. Edge detect adds 1 clk after sync.
//  States: IDLE -> CMD -> DATA -> COMMIT -> DONE -> IDLE.
//   IDLE:   synced ncs falling edge -> CMD, bit counter=0, shift reg=0.
//   CMD:    shift in 1+ADDR_W bits on sclk rises. After last bit: latch rw (1=write, 0=read) and addr,
//           load rd_shift with reg[addr] (0 if addr >= NUM_REGS); -> DATA.
//   DATA:   shift in DATA_W bits on rises. Read: cipo_oe=1; each sclk fall drives cipo=rd_shift MSB
//           then shifts left, so data MSB is valid before the first DATA rise. After DATA_W bits -> COMMIT.
//   COMMIT: exactly 1 clk. Write with addr < NUM_REGS: reg[addr] <= data, wr_stb=1, wr_addr=addr.
//           Write with addr >= NUM_REGS: silently dropped, no wr_stb. Read: no register change. -> DONE.
//   DONE:   extra sclk edges ignored, cipo_oe=0; synced ncs rising edge -> IDLE.
//  Abort: synced ncs rise in CMD or DATA -> IDLE, err_abort=1 for 1 clk, no register change, cipo_oe=0.
//  Simultaneous ncs rise and final data-bit rise in the same clk: abort wins (no write).
//  ncs falling while not IDLE (DONE/COMMIT): ignored; new frame requires ncs high first.
//  Register update visible on regs_flat the clk after COMMIT; read-during-write of same addr is
//   impossible (one frame at a time). cipo holds last value when cipo_oe=0; cipo=0 in IDLE.
//  Reset mid-frame: immediate return to reset values; frame in progress discarded, no wr_stb.
//  Width rules: bit counter sized for max(1+ADDR_W, DATA_W); addr compared unsigned against NUM_REGS.
// TESTING (defaults ADDR_W=7, DATA_W=8, NUM_REGS=5)
//  Write frame 1_0000010_10100101 -> regs_flat[23:16]=8'hA5, one wr_stb pulse with wr_addr=2, others unchanged.
//  Read frame 0_0000010_xxxxxxxx after above -> cipo_oe high in DATA, cipo bits 1,0,1,0,0,1,0,1 on 8 rises.
//  ncs raised after 10 sclk of write to addr 1 -> err_abort one pulse, regs_flat unchanged, no wr_stb.
//  Write 1_0010000_11111111 (addr 16) -> no wr_stb, regs unchanged; read of addr 16 returns 8'h00.
//  rst_n low after 12 bits of write to addr 4 -> regs_flat=RESET_VALS, no wr_stb; next full frame works.
//  Write to addr 0 with 20 sclk pulses -> reg0 set from first 16 bits only, extra edges ignored in DONE.

Source files
------------

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 (MSB first) peripheral exposing NUM_REGS registers
// with write and read-back.
// Frame format: 1 R/W bit (1=write), ADDR_W address bits, DATA_W data bits.
//
// Ports:
//   clk, rst_n  system clock (>= 8x sclk), synchronous active-low reset
//   ncs, sclk   SPI chip select (active low) and clock, both async to clk
//   copi        controller-out peripheral-in serial data, async to clk
//   cipo        controller-in peripheral-out serial data
//   cipo_oe     high only while the bank drives read data
//   regs_flat   all registers, reg i at [i*DATA_W +: DATA_W]
//   wr_stb      one-clk pulse when a register has been written
//   wr_addr     address of that write, valid with wr_stb
//   err_abort   one-clk pulse when ncs rises before the frame is complete
module spi_reg_bank #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ncs,
  input  logic                         sclk,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         err_abort
);

  localparam int CMD_W    = 1 + ADDR_W;
  localparam int MAX_BITS = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    DATA   = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  // Synchronisers. sclk and ncs carry one extra flop so the last two synced
  // samples can be compared for edge detection.
  logic [SYNC_STAGES:0]   sclk_sr, ncs_sr;
  logic [SYNC_STAGES-1:0] copi_sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sr <= '0;
      ncs_sr  <= '0;
      copi_sr <= '0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-1:0], sclk};
      ncs_sr  <= {ncs_sr[SYNC_STAGES-1:0], ncs};
      copi_sr <= {copi_sr[SYNC_STAGES-2:0], copi};
    end
  end

  logic copi_s, sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  assign copi_s    = copi_sr[SYNC_STAGES-1];
  assign sclk_rise =  sclk_sr[SYNC_STAGES-1] & ~sclk_sr[SYNC_STAGES];
  assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] &  sclk_sr[SYNC_STAGES];
  assign ncs_rise  =  ncs_sr[SYNC_STAGES-1]  & ~ncs_sr[SYNC_STAGES];
  assign ncs_fall  = ~ncs_sr[SYNC_STAGES-1]  &  ncs_sr[SYNC_STAGES];

  // Datapath state
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] cmd_sr;     // the R/W bit only matters once complete
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] rd_shift;
  logic              rw;
  logic [ADDR_W-1:0] addr;

  logic [CMD_W-1:0]  cmd_next;
  logic [DATA_W-1:0] data_next;
  logic              addr_ok;
  assign cmd_next  = {cmd_sr, copi_s};
  assign data_next = {data_sr[DATA_W-2:0], copi_s};
  assign addr_ok   = (32'(addr) < NUM_REGS);

  // Unimplemented addresses read as zero.
  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(a) == i) r = regs[i];
    return r;
  endfunction

  // Next-state and control decode
  logic cmd_shift, cmd_last, data_shift, abort, commit;

  always_comb begin
    state_next = state;
    cmd_shift  = 1'b0;
    cmd_last   = 1'b0;
    data_shift = 1'b0;
    abort      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: if (ncs_fall) state_next = CMD;
      CMD: begin
        // Abort is checked first so it wins over a coincident sclk rise.
        if (ncs_rise) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise) begin
          cmd_shift = 1'b1;
          if (bit_cnt == CNT_W'(ADDR_W)) begin
            cmd_last   = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (ncs_rise) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise) begin
          data_shift = 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) state_next = COMMIT;
        end
      end
      COMMIT: begin
        commit = 1'b1;
        // A ncs rise landing in this single cycle must not strand us in DONE.
        state_next = ncs_rise ? IDLE : DONE;
      end
      DONE:    if (ncs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      data_sr   <= '0;
      rd_shift  <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      cipo      <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      err_abort <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALS[i*DATA_W +: DATA_W];
    end else begin
      wr_stb    <= 1'b0;
      err_abort <= abort;
      if (state == IDLE) begin
        bit_cnt <= '0;
        cmd_sr  <= '0;
        data_sr <= '0;
        cipo    <= 1'b0;
      end
      if (cmd_shift) begin
        cmd_sr  <= cmd_next[ADDR_W-1:0];
        bit_cnt <= cmd_last ? '0 : bit_cnt + 1'b1;
        if (cmd_last) begin
          rw       <= cmd_next[CMD_W-1];
          addr     <= cmd_next[ADDR_W-1:0];
          rd_shift <= read_reg(cmd_next[ADDR_W-1:0]);
        end
      end
      if (data_shift) begin
        data_sr <= data_next;
        bit_cnt <= bit_cnt + 1'b1;
      end
      // Driving on falls puts the data MSB on cipo before the first DATA rise.
      if (state == DATA && !rw && sclk_fall) begin
        cipo     <= rd_shift[DATA_W-1];
        rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
      end
      if (commit && rw && addr_ok) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (32'(addr) == i) regs[i] <= data_sr;
        wr_stb  <= 1'b1;
        wr_addr <= addr;
      end
    end
  end

  assign cipo_oe = (state == DATA) && !rw;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank at the default geometry
// (ADDR_W=7, DATA_W=8, NUM_REGS=5) with a non-zero reset image.
module tb_spi_reg_bank;

  localparam logic [39:0] RV = 40'h55_44_33_22_11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ncs = 1'b1;
  logic        sclk = 1'b0;
  logic        copi = 1'b0;
  logic        cipo, cipo_oe, wr_stb, err_abort;
  logic [39:0] regs_flat;
  logic [6:0]  wr_addr;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int abort_cnt = 0;
  logic [6:0] last_wr_addr = '0;

  spi_reg_bank #(
    .ADDR_W(7), .DATA_W(8), .NUM_REGS(5), .SYNC_STAGES(2), .RESET_VALS(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .err_abort(err_abort)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_stb) begin
      wr_cnt++;
      last_wr_addr = wr_addr;
    end
    if (err_abort) abort_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives nbits of word MSB first with sclk at 16 clk per period. Captures
  // cipo just before the rises of bits 8..15 (the data field of a read).
  task automatic spi_frame(input int nbits, input logic [31:0] word,
                           output logic [7:0] rd, output logic oe_ok);
    rd    = '0;
    oe_ok = 1'b1;
    ncs   = 1'b0;
    #160;
    for (int i = 0; i < nbits; i++) begin
      copi = word[nbits-1-i];
      #80;
      if (i >= 8 && i < 16) begin
        rd[15-i] = cipo;
        if (!cipo_oe) oe_ok = 1'b0;
      end
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
    #160;
  endtask

  task automatic ncs_high();
    ncs = 1'b1;
    #320;
  endtask

  logic [7:0]  rd;
  logic        oe_ok;
  logic [39:0] exp_regs;
  int          wr0, ab0;

  initial begin
    exp_regs = RV;
    repeat (5) @(negedge clk);
    check("reset_regs", regs_flat, RV);
    check("reset_cipo", cipo, 1'b0);
    check("reset_oe", cipo_oe, 1'b0);
    check("reset_stb", wr_stb, 1'b0);
    check("reset_abort", err_abort, 1'b0);
    check("reset_wr_addr", wr_addr, 7'd0);
    rst_n = 1'b1;
    #200;

    // Write A5 to reg 2
    wr0 = wr_cnt;
    spi_frame(16, 32'h82A5, rd, oe_ok);
    ncs_high();
    exp_regs[16 +: 8] = 8'hA5;
    check("wr2_regs", regs_flat, exp_regs);
    check("wr2_stb_count", 64'(wr_cnt - wr0), 64'd1);
    check("wr2_addr", last_wr_addr, 7'd2);

    // Read reg 2 back
    wr0 = wr_cnt;
    spi_frame(16, 32'h0200, rd, oe_ok);
    check("rd2_data", rd, 8'hA5);
    check("rd2_oe_in_data", oe_ok, 1'b1);
    check("rd2_oe_after", cipo_oe, 1'b0);
    ncs_high();
    check("rd2_no_stb", 64'(wr_cnt - wr0), 64'd0);
    check("rd2_regs", regs_flat, exp_regs);

    // Abort a write to reg 1 after 10 bits
    wr0 = wr_cnt;
    ab0 = abort_cnt;
    spi_frame(10, 32'h207, rd, oe_ok);
    ncs_high();
    check("abort_pulse", 64'(abort_cnt - ab0), 64'd1);
    check("abort_no_stb", 64'(wr_cnt - wr0), 64'd0);
    check("abort_regs", regs_flat, exp_regs);

    // Write to unimplemented addr 16, then read it
    wr0 = wr_cnt;
    spi_frame(16, 32'h90FF, rd, oe_ok);
    ncs_high();
    check("oor_no_stb", 64'(wr_cnt - wr0), 64'd0);
    check("oor_regs", regs_flat, exp_regs);
    spi_frame(16, 32'h1000, rd, oe_ok);
    ncs_high();
    check("oor_rd_data", rd, 8'h00);
    check("oor_rd_oe", oe_ok, 1'b1);

    // Reset after 12 bits of a write to reg 4
    wr0 = wr_cnt;
    spi_frame(12, 32'h845, rd, oe_ok);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_regs", regs_flat, RV);
    rst_n = 1'b1;
    ncs_high();
    check("midrst_no_stb", 64'(wr_cnt - wr0), 64'd0);
    exp_regs = RV;
    wr0 = wr_cnt;
    spi_frame(16, 32'h845A, rd, oe_ok);
    ncs_high();
    exp_regs[32 +: 8] = 8'h5A;
    check("postrst_regs", regs_flat, exp_regs);
    check("postrst_stb", 64'(wr_cnt - wr0), 64'd1);
    check("postrst_addr", last_wr_addr, 7'd4);

    // 20 sclk pulses writing reg 0: trailing 4 bits ignored
    wr0 = wr_cnt;
    spi_frame(20, 32'h803CF, rd, oe_ok);
    ncs_high();
    exp_regs[0 +: 8] = 8'h3C;
    check("long_regs", regs_flat, exp_regs);
    check("long_stb", 64'(wr_cnt - wr0), 64'd1);
    check("long_addr", last_wr_addr, 7'd0);

    check("abort_total", 64'(abort_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
